// File: rtl/exc_ctrl_if.sv
// Commit-stage / CP0 port bundle for exc_ctrl.
//   master : commit stage side (drives instruction/CP0 state, consumes writes)
//   slave  : exc_ctrl side (consumes commit info, drives CP0 writes/flush/redirect)
interface exc_ctrl_if;
  logic        instr_valid;
  logic [31:0] pc_in;
  logic        in_delay_slot;
  logic        exc_adel;
  logic        exc_ri;
  logic        exc_sys;
  logic        exc_ov;
  logic        exc_ades;
  logic        eret;
  logic [31:0] status_in;
  logic [31:0] cause_in;
  logic [31:0] epc_in;
  logic        cause_w;
  logic [31:0] cause_d;
  logic        epc_w;
  logic [31:0] epc_d;
  logic        status_w;
  logic [31:0] status_d;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    output instr_valid, pc_in, in_delay_slot, exc_adel, exc_ri, exc_sys,
           exc_ov, exc_ades, eret, status_in, cause_in, epc_in,
    input  cause_w, cause_d, epc_w, epc_d, status_w, status_d,
           flush, redirect, redirect_pc, busy
  );

  modport slave (
    input  instr_valid, pc_in, in_delay_slot, exc_adel, exc_ri, exc_sys,
           exc_ov, exc_ades, eret, status_in, cause_in, epc_in,
    output cause_w, cause_d, epc_w, epc_d, status_w, status_d,
           flush, redirect, redirect_pc, busy
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception / interrupt controller beside the commit stage.
// Prioritises interrupts and synchronous exceptions, commits Cause/EPC/Status,
// flushes the pipe and redirects fetch to EXC_VECTOR; also executes ERET.
// Ports:
//   clk, rst_n : clock (rising) / async active-low reset
//   irq[5:0]   : async level-sensitive hardware interrupt lines
//   bus        : exc_ctrl_if.slave -- commit info in, CP0 write pulses,
//                flush, redirect and busy out
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180,
  parameter int          SYNC_STAGES = 2             // must be >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  irq,
  exc_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COMMIT, VECTOR, RETURN} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic [5:0]  irq_prev_q, irq_prev_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] pc_q, pc_d;

  logic [5:0]  ip_s;
  logic        int_req;
  logic        exc_any;
  logic [4:0]  exc_code;

  // Synchroniser: index 0 samples the pin, the top stage is the clean copy.
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], irq};
  assign ip_s = sync_q[SYNC_STAGES-1];

  assign int_req = bus.status_in[0] & ~bus.status_in[1] &
                   (|(ip_s & bus.status_in[15:10]));

  // Fixed priority encoder; the interrupt wins over every sync exception.
  always_comb begin
    exc_any  = 1'b1;
    exc_code = 5'd0;
    if      (int_req)      exc_code = 5'd0;
    else if (bus.exc_adel) exc_code = 5'd4;
    else if (bus.exc_ri)   exc_code = 5'd10;
    else if (bus.exc_sys)  exc_code = 5'd8;
    else if (bus.exc_ov)   exc_code = 5'd12;
    else if (bus.exc_ades) exc_code = 5'd5;
    else                   exc_any  = 1'b0;
  end

  always_comb begin
    state_d         = state_q;
    irq_prev_d      = irq_prev_q;
    code_d          = code_q;
    bd_d            = bd_q;
    pc_d            = pc_q;
    bus.cause_w     = 1'b0;
    bus.cause_d     = '0;
    bus.epc_w       = 1'b0;
    bus.epc_d       = '0;
    bus.status_w    = 1'b0;
    bus.status_d    = '0;
    bus.flush       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    case (state_q)
      IDLE: begin
        if (bus.instr_valid && exc_any) begin
          // an exception/interrupt drops a simultaneous eret
          state_d = COMMIT;
          code_d  = exc_code;
          bd_d    = bus.in_delay_slot;
          pc_d    = bus.pc_in;
        end else if (bus.instr_valid && bus.eret) begin
          state_d = RETURN;
        end else begin
          // No event this cycle: mirror any change of pending lines into Cause.IP
          if (ip_s != irq_prev_q) begin
            bus.cause_w = 1'b1;
            bus.cause_d = {bus.cause_in[31:16], ip_s, bus.cause_in[9:0]};
          end
          irq_prev_d = ip_s;
        end
      end
      COMMIT: begin
        bus.cause_w  = 1'b1;
        bus.cause_d  = {bd_q, bus.cause_in[30:16], ip_s, bus.cause_in[9:7],
                        code_q, bus.cause_in[1:0]};
        bus.epc_w    = 1'b1;
        bus.epc_d    = bd_q ? (pc_q - 32'd4) : pc_q;   // wraps at 0
        bus.status_w = 1'b1;
        bus.status_d = bus.status_in | 32'h2;
        bus.flush    = 1'b1;
        state_d      = VECTOR;
      end
      VECTOR: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = EXC_VECTOR;
        state_d         = IDLE;
      end
      RETURN: begin
        bus.status_w    = 1'b1;
        bus.status_d    = bus.status_in & ~32'h2;
        bus.flush       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = bus.epc_in;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      irq_prev_q <= '0;
      code_q     <= '0;
      bd_q       <= 1'b0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      irq_prev_q <= irq_prev_d;
      code_q     <= code_d;
      bd_q       <= bd_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] irq;
  int tests = 0;
  int fails = 0;

  exc_ctrl_if bus();

  exc_ctrl #(.EXC_VECTOR(32'h8000_0180), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cause_w;
    logic [31:0] cause_d;
    logic        epc_w;
    logic [31:0] epc_d;
    logic        status_w;
    logic [31:0] status_d;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
  } obs_t;

  obs_t sb[$];
  obs_t mon_o, mon_e;

  function automatic obs_t rec(logic cw, logic [31:0] cd, logic ew, logic [31:0] ed,
                               logic sw, logic [31:0] sd, logic fl, logic rd,
                               logic [31:0] rpc);
    obs_t r;
    r = '{cause_w:cw, cause_d:cd, epc_w:ew, epc_d:ed, status_w:sw, status_d:sd,
          flush:fl, redirect:rd, redirect_pc:rpc};
    return r;
  endfunction

  task automatic exp_commit(input logic [31:0] c, input logic [31:0] e, input logic [31:0] s);
    sb.push_back(rec(1, c, 1, e, 1, s, 1, 0, 32'h0));
    sb.push_back(rec(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0180));
  endtask

  task automatic exp_ip(input logic [31:0] c);
    sb.push_back(rec(1, c, 0, 0, 0, 0, 0, 0, 32'h0));
  endtask

  task automatic exp_ret(input logic [31:0] s, input logic [31:0] rpc);
    sb.push_back(rec(0, 0, 0, 0, 1, s, 1, 1, rpc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_ev();
    bus.instr_valid = 0; bus.exc_adel = 0; bus.exc_ri = 0; bus.exc_sys = 0;
    bus.exc_ov = 0; bus.exc_ades = 0; bus.eret = 0; bus.in_delay_slot = 0;
  endtask

  // Scoreboard monitor: every cycle with a pulse pops one expected record;
  // quiet cycles must show all data outputs at zero.
  always @(negedge clk) begin
    mon_o = rec(bus.cause_w, bus.cause_d, bus.epc_w, bus.epc_d, bus.status_w,
                bus.status_d, bus.flush, bus.redirect, bus.redirect_pc);
    if (mon_o.cause_w | mon_o.epc_w | mon_o.status_w | mon_o.flush | mon_o.redirect) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL sb_unexpected got=%h exp=none", mon_o);
      end else begin
        mon_e = sb.pop_front();
        assert (mon_o === mon_e) else begin
          fails++;
          $error("FAIL sb_pulse got=%h exp=%h", mon_o, mon_e);
        end
      end
    end else begin
      tests++;
      assert (mon_o === obs_t'(0)) else begin
        fails++;
        $error("FAIL quiet_zero got=%h exp=0", mon_o);
      end
    end
  end

  initial begin
    rst_n = 1; irq = 0;
    clear_ev();
    bus.pc_in = 0; bus.status_in = 32'h0000_FF01; bus.cause_in = 0; bus.epc_in = 0;
    #1 rst_n = 0;
    step(); step();
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_flush", {31'b0, bus.flush}, 32'h0);
    rst_n = 1;
    step();

    // Syscall
    bus.instr_valid = 1; bus.exc_sys = 1; bus.pc_in = 32'h0040_0010;
    exp_commit(32'h0000_0020, 32'h0040_0010, 32'h0000_FF03);
    step(); check("sys_busy", {31'b0, bus.busy}, 32'h1);
    clear_ev();
    step(); step();
    check("sys_idle", {31'b0, bus.busy}, 32'h0);

    // RI beats Ov, delay slot
    bus.cause_in = 32'h0000_0300;
    bus.instr_valid = 1; bus.exc_ov = 1; bus.exc_ri = 1; bus.in_delay_slot = 1;
    bus.pc_in = 32'h0040_0024;
    exp_commit(32'h8000_0328, 32'h0040_0020, 32'h0000_FF03);
    step(); clear_ev(); step(); step();

    // EPC wraparound at pc 0 in delay slot
    bus.cause_in = 0;
    bus.instr_valid = 1; bus.exc_adel = 1; bus.in_delay_slot = 1; bus.pc_in = 0;
    exp_commit(32'h8000_0010, 32'hFFFF_FFFC, 32'h0000_FF03);
    step(); clear_ev(); step(); step();

    // Interrupt: IP update after sync, then taken by next instruction
    irq = 6'b000100;
    exp_ip(32'h0000_1000);
    step(); step(); step();
    bus.instr_valid = 1; bus.pc_in = 32'h0040_0040;
    exp_commit(32'h0000_1000, 32'h0040_0040, 32'h0000_FF03);
    step(); clear_ev(); step(); step();

    // EXL set: IP update only, no exception
    irq = 0;
    exp_ip(32'h0);
    step(); step(); step();
    bus.status_in = 32'h0000_FF03;
    irq = 6'b000100;
    exp_ip(32'h0000_1000);
    step(); step(); step();
    bus.instr_valid = 1; bus.pc_in = 32'h0040_0050;
    step();
    check("exl_no_take", {31'b0, bus.busy}, 32'h0);
    clear_ev();
    irq = 0;
    exp_ip(32'h0);
    step(); step(); step();

    // ERET
    bus.epc_in = 32'h0040_0100;
    bus.instr_valid = 1; bus.eret = 1;
    exp_ret(32'h0000_FF01, 32'h0040_0100);
    step(); check("eret_busy", {31'b0, bus.busy}, 32'h1);
    clear_ev();
    step(); check("eret_idle", {31'b0, bus.busy}, 32'h0);

    // ERET with AdES: exception wins
    bus.instr_valid = 1; bus.eret = 1; bus.exc_ades = 1; bus.pc_in = 32'h0040_0200;
    exp_commit(32'h0000_0014, 32'h0040_0200, 32'h0000_FF03);
    step(); clear_ev(); step(); step();

    // Busy: events held through COMMIT/VECTOR are ignored
    bus.status_in = 32'h0000_FF01;
    bus.instr_valid = 1; bus.exc_sys = 1; bus.pc_in = 32'h0040_0300;
    exp_commit(32'h0000_0020, 32'h0040_0300, 32'h0000_FF03);
    step(); check("busy_commit", {31'b0, bus.busy}, 32'h1);
    step(); check("busy_vector", {31'b0, bus.busy}, 32'h1);
    step(); clear_ev();
    step(); step();

    // Reset mid-COMMIT aborts the sequence
    bus.instr_valid = 1; bus.exc_sys = 1; bus.pc_in = 32'h0040_0400;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("rstmid_cause_w", {31'b0, bus.cause_w}, 32'h0);
    check("rstmid_flush", {31'b0, bus.flush}, 32'h0);
    check("rstmid_status_w", {31'b0, bus.status_w}, 32'h0);
    check("rstmid_busy", {31'b0, bus.busy}, 32'h0);
    clear_ev();
    step(); rst_n = 1;
    step(); step(); step();
    check("rstmid_after", {31'b0, bus.busy}, 32'h0);

    check("sb_drain", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt controller that drives the CP0 write ports: produces the write-enable/data pairs for Cause, EPC and Status.
- Sits beside the pipeline's commit stage. Detects synchronous exceptions and hardware interrupts, prioritises them, commits CP0 state, flushes the pipeline and redirects fetch to the vector.
- Also executes ERET: clears EXL and redirects to EPC.

Parameters:
- EXC_VECTOR, 32'h8000_0180, fetch address on any exception/interrupt
- SYNC_STAGES, 2, flop stages on each irq line (min 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- irq  in  6  async hardware interrupt lines, level-sensitive
- instr_valid  in  1  commit stage holds a valid instruction this cycle
- pc_in  in  32  PC of committing instruction
- in_delay_slot  in  1  committing instruction is in a branch delay slot
- exc_adel  in  1  address error on load/fetch
- exc_ri  in  1  reserved instruction
- exc_sys  in  1  syscall
- exc_ov  in  1  arithmetic overflow
- exc_ades  in  1  address error on store
- eret  in  1  committing instruction is ERET
- status_in  in  32  current Status (IE=bit0, EXL=bit1, IM=bits15:8)
- cause_in  in  32  current Cause
- epc_in  in  32  current EPC
- cause_w / cause_d  out  1/32  Cause write enable / data
- epc_w / epc_d  out  1/32  EPC write enable / data
- status_w / status_d  out  1/32  Status write enable / data
- flush  out  1  kill all younger in-flight instructions
- redirect / redirect_pc  out  1/32  fetch redirect strobe / target
- busy  out  1  FSM not IDLE; commit stage must stall

Behaviour:
- Reset: all outputs 0, FSM=IDLE, sync chains and irq_prev cleared. Reset asserted mid-operation aborts any pending commit or redirect; no write pulse is emitted.
- irq sync: each line passes through SYNC_STAGES flops, giving ip_s[5:0].
- Interrupt qualification: int_req = IE & ~EXL & |(ip_s & IM[15:10]).
- Event evaluation happens in IDLE only, and only when instr_valid=1.
- Priority, highest first:
  - Int, ExcCode 0
  - AdEL, 4
  - RI, 10
  - Sys, 8
  - Ov, 12
  - AdES, 5
  - ERET, lowest
- Any exception or interrupt outranks a simultaneous eret; the eret is dropped.
- FSM states: IDLE, COMMIT, VECTOR, RETURN.
- IDLE, exception/interrupt selected:
  - Latch ExcCode, BD=in_delay_slot, pc_in.
  - Go to COMMIT. busy=1 from the next cycle.
- COMMIT, exactly 1 cycle. Pulse cause_w, epc_w, status_w and flush.
  - cause_d = cause_in with bit31=BD, bits15:10=ip_s, bits6:2=ExcCode, other bits preserved.
  - epc_d = BD ? pc-4 : pc, with 32-bit wraparound (pc 0 in a delay slot gives 32'hFFFF_FFFC).
  - status_d = status_in | 32'h2 (EXL set).
  - Next state VECTOR.
- VECTOR, exactly 1 cycle: redirect=1, redirect_pc=EXC_VECTOR, then IDLE.
- Total latency: event in cycle T, CP0 writes at T+1, redirect at T+2, new events accepted at T+3.
- IDLE, eret with no exception: go to RETURN.
- RETURN, exactly 1 cycle:
  - Pulse status_w with status_d = status_in & ~32'h2.
  - Pulse flush and redirect, with redirect_pc=epc_in.
  - Next state IDLE.
- IP tracking: in IDLE with no event taken, if ip_s != irq_prev, pulse cause_w for 1 cycle with cause_d = cause_in with bits15:10=ip_s. Then irq_prev <= ip_s. This applies regardless of instr_valid.
- All write, flush and redirect outputs are single-cycle pulses. Data outputs hold 0 when their write enable is 0.
- Events presented while busy=1 are ignored; upstream stalls.

Test Plan:
- Reset: rst_n=0 mid-COMMIT → all outputs 0 immediately. After release, FSM=IDLE and no stray cause_w.
- Syscall: instr_valid=1, exc_sys=1, pc_in=32'h0040_0010, BD=0, status_in=32'h0000_FF01 → next cycle:
  - cause_w with cause_d[6:2]=8
  - epc_d=32'h0040_0010
  - status_d=32'h0000_FF03, flush=1
  - following cycle redirect_pc=32'h8000_0180
- Delay slot plus priority: exc_ov=1 and exc_ri=1, in_delay_slot=1, pc_in=32'h0040_0024 → ExcCode=10, cause_d[31]=1, epc_d=32'h0040_0020.
- Interrupt: irq[2]=1 with IE=1, EXL=0, IM=8'hFF:
  - after SYNC_STAGES cycles, cause_w IP update (bit12=1)
  - next valid instruction takes ExcCode 0
  - with EXL=1 instead → IP update only, no flush.
- ERET: eret=1, epc_in=32'h0040_0100, status_in=32'h0000_FF03 → status_d=32'h0000_FF01, redirect_pc=32'h0040_0100. eret together with exc_ades → exception wins, ExcCode=5.
- Busy: exc_sys asserted during COMMIT/VECTOR → ignored. Exactly one COMMIT sequence observed.
